// File: rtl/mem_byte_arbiter.sv
// Round-robin arbiter that serialises fetch and data accesses onto a byte-wide
// RAM, one little-endian byte per cycle, and reassembles read words.
module mem_byte_arbiter #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_of = w[7:0];
            2'd1:    byte_of = w[15:8];
            2'd2:    byte_of = w[23:16];
            default: byte_of = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    state_t        state_r, state_s;
    logic          owner_r, owner_s;        // 1 = data port owns the transfer
    logic          last_r, last_s;          // 1 = data port was granted last
    logic [AW-1:0] base_r, base_s;
    logic          we_r, we_s;
    logic [31:0]   wdata_r, wdata_s;
    logic [2:0]    n_r, n_s;
    logic [1:0]    idx_r, idx_s;
    logic [31:0]   asm_r, asm_s;
    logic [31:0]   if_rdata_r, if_rdata_s;
    logic [31:0]   d_rdata_r, d_rdata_s;
    logic          if_done_r, d_done_r, d_err_r, err_s, busy_r;
    logic          mem_en_r, mem_en_s, mem_we_r, mem_we_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]    mem_wdata_r, mem_wdata_s;
    logic          grant_data_s;
    logic [2:0]    nm1_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        base_s      = base_r;
        we_s        = we_r;
        wdata_s     = wdata_r;
        n_s         = n_r;
        idx_s       = idx_r;
        asm_s       = asm_r;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        err_s       = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        nm1_s       = n_r - 3'd1;
        grant_data_s = d_req && (!if_req || !last_r);
        case (state_r)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_s = grant_data_s;
                    last_s  = grant_data_s;
                    idx_s   = 2'd0;
                    asm_s   = 32'd0;
                    if (grant_data_s) begin
                        base_s  = d_addr;
                        we_s    = d_we;
                        wdata_s = d_wdata;
                        case (d_size)
                            2'd0:    n_s = 3'd1;
                            2'd1:    n_s = 3'd2;
                            default: n_s = 3'd4;
                        endcase
                    end else begin
                        base_s  = if_addr;
                        we_s    = 1'b0;
                        wdata_s = 32'd0;
                        n_s     = 3'd4;
                    end
                    if (grant_data_s && (d_size == 2'd3)) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                    end else begin
                        state_s     = XFER;
                        mem_en_s    = 1'b1;
                        mem_we_s    = we_s;
                        mem_addr_s  = base_s;
                        mem_wdata_s = byte_of(wdata_s, 2'd0);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                // The byte requested last cycle is on mem_rdata now.
                if (!we_r && (idx_r != 2'd0)) begin
                    asm_s = put_byte(asm_r, idx_r - 2'd1, mem_rdata);
                end else begin
                    asm_s = asm_r;
                end
                if ({1'b0, idx_r} == nm1_s) begin
                    state_s = we_r ? DONE : WAIT;
                end else begin
                    idx_s       = idx_r + 2'd1;
                    mem_en_s    = 1'b1;
                    mem_we_s    = we_r;
                    mem_addr_s  = base_r + {{(AW-2){1'b0}}, idx_s};
                    mem_wdata_s = byte_of(wdata_r, idx_s);
                end
            end
            WAIT: begin
                asm_s   = put_byte(asm_r, nm1_s[1:0], mem_rdata);
                state_s = DONE;
                if (owner_r) begin
                    d_rdata_s = asm_s;
                end else begin
                    if_rdata_s = asm_s;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            base_r      <= '0;
            we_r        <= 1'b0;
            wdata_r     <= 32'd0;
            n_r         <= 3'd0;
            idx_r       <= 2'd0;
            asm_r       <= 32'd0;
            if_rdata_r  <= 32'd0;
            d_rdata_r   <= 32'd0;
            if_done_r   <= 1'b0;
            d_done_r    <= 1'b0;
            d_err_r     <= 1'b0;
            busy_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            base_r      <= base_s;
            we_r        <= we_s;
            wdata_r     <= wdata_s;
            n_r         <= n_s;
            idx_r       <= idx_s;
            asm_r       <= asm_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
            if_done_r   <= (state_s == DONE) && !owner_s;
            d_done_r    <= (state_s == DONE) && owner_s;
            d_err_r     <= err_s;
            busy_r      <= (state_s != IDLE);
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign if_done   = if_done_r;
    assign if_rdata  = if_rdata_r;
    assign d_done    = d_done_r;
    assign d_rdata   = d_rdata_r;
    assign d_err     = d_err_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule
